// File: rtl/mem_map_ctrl_pkg.sv
// Package: mem_map_ctrl_pkg
// Shared definitions for the memory-map / MMIO stage:
//   - region codes carried in addr[31:28]
//   - IO register offsets carried in addr[7:0]
//   - read-source selector registered alongside a load
//   - helper mapping a region code to its read source
package mem_map_ctrl_pkg;

  // Region codes (addr[31:28])
  localparam logic [3:0] REG_DMEM = 4'b0001;  // DMEM read/write
  localparam logic [3:0] REG_IMEM = 4'b0010;  // IMEM write only
  localparam logic [3:0] REG_DMIM = 4'b0011;  // DMEM+IMEM write, DMEM read
  localparam logic [3:0] REG_BIOS = 4'b0100;  // BIOS read only
  localparam logic [3:0] REG_IO   = 4'b1000;  // memory-mapped IO

  // IO register offsets (addr[7:0])
  localparam logic [7:0] IO_UART_CTRL = 8'h00;
  localparam logic [7:0] IO_UART_RX   = 8'h04;
  localparam logic [7:0] IO_UART_TX   = 8'h08;
  localparam logic [7:0] IO_CYC_CTR   = 8'h10;
  localparam logic [7:0] IO_INST_CTR  = 8'h14;
  localparam logic [7:0] IO_CTR_RST   = 8'h18;

  // Which source drives rdata in the cycle after a load
  typedef enum logic [1:0] {
    RD_NONE,
    RD_DMEM,
    RD_BIOS,
    RD_IO
  } rd_src_e;

  // IMEM is write-only, so it maps to RD_NONE like unmapped space.
  function automatic rd_src_e rd_src_of(input logic [3:0] region);
    case (region)
      REG_DMEM, REG_DMIM: return RD_DMEM;
      REG_BIOS:           return RD_BIOS;
      REG_IO:             return RD_IO;
      default:            return RD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_map_ctrl_io_counters.sv
// Module: io_counters
// Free-running cycle counter and retired-instruction counter.
// Both wrap modulo 2^CTR_W and are cleared together; clear has priority over
// a same-cycle increment.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        clear both counters at this edge
//   inst_retire  one instruction retired this cycle
//   cyc_count    cycle counter value
//   inst_count   instruction counter value
module io_counters #(
  parameter int unsigned CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inst_retire,
  output logic [CTR_W-1:0] cyc_count,
  output logic [CTR_W-1:0] inst_count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cyc_count  <= '0;
      inst_count <= '0;
    end else begin
      cyc_count <= cyc_count + CTR_W'(1);
      if (inst_retire) inst_count <= inst_count + CTR_W'(1);
    end
  end

endmodule

// File: rtl/mem_map_ctrl.sv
// Module: mem_map_ctrl
// Address decode and MMIO stage beside the load/store byte-lane decoder.
// Routes lane-aligned store data/byte enables to DMEM, IMEM or IO registers
// (same cycle, combinational) and returns the 32-bit load word one cycle
// after the load, matching the BRAM read latency.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   addr, wdata, wen, ren          execute-stage load/store request
//   pc_in_bios                     IMEM writes allowed only while running BIOS
//   inst_retire                    retire pulse for the instruction counter
//   dmem_addr/we/din, dmem_dout    DMEM port
//   imem_addr/we/din               IMEM write port
//   bios_addr, bios_dout           BIOS read port
//   rdata                          load word, valid the cycle after ren
//   uart_tx_*                      transmit ready/valid (this block is source)
//   uart_rx_*                      receive ready/valid (this block is sink)
module mem_map_ctrl
  import mem_map_ctrl_pkg::*;
#(
  parameter int unsigned DMEM_AW = 14,
  parameter int unsigned IMEM_AW = 14,
  parameter int unsigned BIOS_AW = 12,
  parameter int unsigned CTR_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wen,
  input  logic               ren,
  input  logic               pc_in_bios,
  input  logic               inst_retire,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_we,
  output logic [31:0]        dmem_din,
  input  logic [31:0]        dmem_dout,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [3:0]         imem_we,
  output logic [31:0]        imem_din,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [31:0]        bios_dout,
  output logic [31:0]        rdata,
  output logic [7:0]         uart_tx_data,
  output logic               uart_tx_valid,
  input  logic               uart_tx_ready,
  input  logic [7:0]         uart_rx_data,
  input  logic               uart_rx_valid,
  output logic               uart_rx_ready
);

  logic [3:0]       region;
  logic [7:0]       io_off;
  logic             is_io;
  logic             is_store;
  logic             tx_load;
  logic             ctr_clear;
  logic [31:0]      io_word;
  logic [31:0]      io_word_q;
  rd_src_e          rd_src_q;
  logic [CTR_W-1:0] cyc_count;
  logic [CTR_W-1:0] inst_count;
  logic             unused_addr;

  assign region   = addr[31:28];
  assign io_off   = addr[7:0];
  assign is_io    = (region == REG_IO);
  assign is_store = |wen;

  // Only the region and offset fields plus the word index are decoded.
  assign unused_addr = ^addr;

  assign dmem_addr = addr[DMEM_AW+1:2];
  assign imem_addr = addr[IMEM_AW+1:2];
  assign bios_addr = addr[BIOS_AW+1:2];
  assign dmem_din  = wdata;
  assign imem_din  = wdata;

  always_comb begin
    dmem_we = '0;
    imem_we = '0;
    if (rst_n) begin
      if (region == REG_DMEM || region == REG_DMIM) dmem_we = wen;
      if ((region == REG_IMEM || region == REG_DMIM) && pc_in_bios) imem_we = wen;
    end
  end

  // A store to the TX register is only accepted while no byte is pending.
  assign tx_load   = is_io && (io_off == IO_UART_TX) && is_store && !uart_tx_valid;
  assign ctr_clear = is_io && (io_off == IO_CTR_RST) && is_store;

  assign uart_rx_ready = rst_n && ren && is_io && (io_off == IO_UART_RX) && uart_rx_valid;

  always_comb begin
    io_word = '0;
    case (io_off)
      IO_UART_CTRL: io_word = {30'b0, uart_rx_valid, uart_tx_ready};
      IO_UART_RX:   io_word = uart_rx_valid ? {24'b0, uart_rx_data} : '0;
      IO_CYC_CTR:   io_word = 32'(cyc_count);
      IO_INST_CTR:  io_word = 32'(inst_count);
      default:      io_word = '0;
    endcase
  end

  io_counters #(
    .CTR_W(CTR_W)
  ) u_io_counters (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (ctr_clear),
    .inst_retire(inst_retire),
    .cyc_count  (cyc_count),
    .inst_count (inst_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
      rd_src_q      <= RD_NONE;
      io_word_q     <= '0;
    end else begin
      if (uart_tx_valid && uart_tx_ready) begin
        uart_tx_valid <= 1'b0;
      end else if (tx_load) begin
        uart_tx_valid <= 1'b1;
        uart_tx_data  <= wdata[7:0];
      end
      // Non-load cycles register RD_NONE so rdata idles at zero.
      rd_src_q  <= ren ? rd_src_of(region) : RD_NONE;
      io_word_q <= (ren && is_io) ? io_word : '0;
    end
  end

  always_comb begin
    rdata = '0;
    case (rd_src_q)
      RD_DMEM: rdata = dmem_dout;
      RD_BIOS: rdata = bios_dout;
      RD_IO:   rdata = io_word_q;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Testbench: tb_mem_map_ctrl
// Self-checking bench for mem_map_ctrl with BRAM/BIOS environment models,
// a reference word memory and a reference counter model.
module tb_mem_map_ctrl;

  localparam int unsigned CW   = 8;
  localparam int unsigned MASK = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic [3:0]  wen;
  logic        ren, pc_in_bios, inst_retire;
  logic [13:0] dmem_addr, imem_addr;
  logic [11:0] bios_addr;
  logic [3:0]  dmem_we, imem_we;
  logic [31:0] dmem_din, imem_din, dmem_dout, bios_dout, rdata;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;

  int errors = 0;
  int checks = 0;

  mem_map_ctrl #(
    .DMEM_AW(14),
    .IMEM_AW(14),
    .BIOS_AW(12),
    .CTR_W  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .wdata        (wdata),
    .wen          (wen),
    .ren          (ren),
    .pc_in_bios   (pc_in_bios),
    .inst_retire  (inst_retire),
    .dmem_addr    (dmem_addr),
    .dmem_we      (dmem_we),
    .dmem_din     (dmem_din),
    .dmem_dout    (dmem_dout),
    .imem_addr    (imem_addr),
    .imem_we      (imem_we),
    .imem_din     (imem_din),
    .bios_addr    (bios_addr),
    .bios_dout    (bios_dout),
    .rdata        (rdata),
    .uart_tx_data (uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready)
  );

  always #5 clk = ~clk;

  // Environment: DMEM BRAM (read-first, byte-write) and a patterned BIOS ROM.
  logic [31:0] dram [0:16383];
  initial for (int i = 0; i < 16384; i++) dram[i] = '0;
  always @(posedge clk) begin
    dmem_dout <= dram[dmem_addr];
    for (int b = 0; b < 4; b++)
      if (dmem_we[b]) dram[dmem_addr][8*b +: 8] <= dmem_din[8*b +: 8];
  end
  always @(posedge clk) bios_dout <= {20'hB105A, bios_addr};

  // Reference model: expected DMEM contents by word index, and counter values.
  logic [31:0] ref_mem [int];
  int unsigned m_cyc = 0, m_inst = 0;

  function automatic logic [31:0] ref_rd(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n || (addr[31:28] == 4'h8 && addr[7:0] == 8'h18 && wen != 4'h0)) begin
      m_cyc  <= 0;
      m_inst <= 0;
    end else begin
      m_cyc <= (m_cyc + 1) & MASK;
      if (inst_retire) m_inst <= (m_inst + 1) & MASK;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    addr = '0; wdata = '0; wen = '0; ren = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pc_in_bios = 1'b1;
    addr = 32'h3000_0040; wen = 4'hF; wdata = 32'h1234_5678;
    #1;
    checks++;
    if (dmem_we !== 4'h0) begin errors++; $display("FAIL reset_dmem_we: got %h expected 0", dmem_we); end
    checks++;
    if (imem_we !== 4'h0) begin errors++; $display("FAIL reset_imem_we: got %h expected 0", imem_we); end
    wen = '0; addr = 32'h8000_0004; ren = 1'b1; uart_rx_valid = 1'b1;
    #1;
    checks++;
    if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b expected 0", uart_rx_ready); end
    tick(); tick();
    checks++;
    if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00)
      begin errors++; $display("FAIL reset_tx: got valid=%b data=%h expected 0/00", uart_tx_valid, uart_tx_data); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    idle(); uart_rx_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_dmem_basic();
    addr = 32'h1000_0010; wen = 4'hF; wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (dmem_we !== 4'hF || dmem_addr !== 14'd4 || dmem_din !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL sw_dmem: got we=%h addr=%0d din=%h expected F/4/deadbeef", dmem_we, dmem_addr, dmem_din); end
    ref_mem[4] = 32'hDEAD_BEEF;
    tick();
    wen = '0; ren = 1'b1;
    tick();
    ren = 1'b0;
    checks++;
    if (rdata !== ref_rd(4)) begin errors++; $display("FAIL lw_dmem: got %h expected %h", rdata, ref_rd(4)); end
    idle();
  endtask

  task automatic test_imem_gate();
    addr = 32'h2000_0000; wen = 4'hF; wdata = 32'hCAFE_F00D; pc_in_bios = 1'b0;
    #1;
    checks++;
    if (imem_we !== 4'h0 || dmem_we !== 4'h0)
      begin errors++; $display("FAIL imem_gate_off: got imem_we=%h dmem_we=%h expected 0/0", imem_we, dmem_we); end
    pc_in_bios = 1'b1;
    #1;
    checks++;
    if (imem_we !== 4'hF || imem_addr !== 14'd0 || imem_din !== 32'hCAFE_F00D)
      begin errors++; $display("FAIL imem_gate_on: got we=%h addr=%0d din=%h expected F/0/cafef00d", imem_we, imem_addr, imem_din); end
    idle();
    tick();
  endtask

  task automatic test_random_mem();
    bit [3:0] st_regs [5] = '{4'h1, 4'h3, 4'h2, 4'h4, 4'h9};
    bit [3:0] ld_regs [6] = '{4'h1, 4'h3, 4'h2, 4'h4, 4'h0, 4'h9};
    for (int it = 0; it < 80; it++) begin
      int          widx;
      bit [3:0]    rg;
      logic [31:0] exp_rd, merged;
      logic [3:0]  exp_dwe, exp_iwe;
      widx = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) begin
        rg = st_regs[$urandom_range(0, 4)];
        wen = 4'($urandom_range(1, 15));
        wdata = $urandom;
        pc_in_bios = 1'($urandom_range(0, 1));
        addr = {rg, 28'(widx * 4)};
        ren = 1'b0;
        exp_dwe = (rg == 4'h1 || rg == 4'h3) ? wen : 4'h0;
        exp_iwe = ((rg == 4'h2 || rg == 4'h3) && pc_in_bios) ? wen : 4'h0;
        #1;
        checks++;
        if (dmem_we !== exp_dwe || imem_we !== exp_iwe)
          begin errors++; $display("FAIL rand_we: addr=%h got dmem_we=%h imem_we=%h expected %h/%h", addr, dmem_we, imem_we, exp_dwe, exp_iwe); end
        if (exp_dwe != 4'h0) begin
          merged = ref_rd(widx);
          for (int b = 0; b < 4; b++) if (wen[b]) merged[8*b +: 8] = wdata[8*b +: 8];
          ref_mem[widx] = merged;
        end
        exp_rd = 32'h0;
      end else begin
        rg = ld_regs[$urandom_range(0, 5)];
        wen = '0;
        ren = 1'b1;
        addr = {rg, 28'(widx * 4)};
        if (rg == 4'h1 || rg == 4'h3) exp_rd = ref_rd(widx);
        else if (rg == 4'h4)          exp_rd = {20'hB105A, 12'(widx)};
        else                          exp_rd = 32'h0;
      end
      tick();
      checks++;
      if (rdata !== exp_rd)
        begin errors++; $display("FAIL rand_rdata: it=%0d region=%h idx=%0d got %h expected %h", it, rg, widx, rdata, exp_rd); end
    end
    idle();
    tick();
  endtask

  task automatic test_tx();
    logic [7:0] b1, b2;
    b1 = 8'($urandom_range(0, 255));
    b2 = ~b1;
    uart_tx_ready = 1'b0;
    addr = 32'h8000_0008; wen = 4'h1; wdata = {24'($urandom), b1};
    tick();
    idle();
    checks++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== b1)
      begin errors++; $display("FAIL tx_load: got valid=%b data=%h expected 1/%h", uart_tx_valid, uart_tx_data, b1); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (uart_tx_valid !== 1'b1 || uart_tx_data !== b1)
        begin errors++; $display("FAIL tx_hold: cyc=%0d got valid=%b data=%h expected 1/%h", i, uart_tx_valid, uart_tx_data, b1); end
    end
    addr = 32'h8000_0008; wen = 4'h1; wdata = {24'h0, b2};
    tick();
    idle();
    checks++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== b1)
      begin errors++; $display("FAIL tx_drop: got valid=%b data=%h expected 1/%h", uart_tx_valid, uart_tx_data, b1); end
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    checks++;
    if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_accept: got valid=%b expected 0", uart_tx_valid); end
    addr = 32'h8000_0008; wen = 4'hF; wdata = {24'h0, b2};
    tick();
    idle();
    checks++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== b2)
      begin errors++; $display("FAIL tx_reload: got valid=%b data=%h expected 1/%h", uart_tx_valid, uart_tx_data, b2); end
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    logic [7:0]  d;
    logic [31:0] exp_st;
    d = 8'($urandom_range(1, 255));
    uart_rx_valid = 1'b1; uart_rx_data = d;
    addr = 32'h8000_0004; ren = 1'b1;
    #1;
    checks++;
    if (uart_rx_ready !== 1'b1) begin errors++; $display("FAIL rx_pop: got %b expected 1", uart_rx_ready); end
    tick();
    ren = 1'b0;
    uart_rx_data = ~d;
    #1;
    checks++;
    if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_pulse_end: got %b expected 0", uart_rx_ready); end
    checks++;
    if (rdata !== {24'h0, d}) begin errors++; $display("FAIL rx_data: got %h expected %h", rdata, {24'h0, d}); end
    addr = 32'h8000_0010; ren = 1'b1;
    #1;
    checks++;
    if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_wrong_off: got %b expected 0", uart_rx_ready); end
    uart_rx_valid = 1'b0;
    addr = 32'h8000_0004;
    #1;
    checks++;
    if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_empty_pop: got %b expected 0", uart_rx_ready); end
    tick();
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL rx_empty_data: got %h expected 0", rdata); end
    for (int i = 0; i < 4; i++) begin
      uart_rx_valid = 1'($urandom_range(0, 1));
      uart_tx_ready = 1'($urandom_range(0, 1));
      exp_st = {30'h0, uart_rx_valid, uart_tx_ready};
      addr = 32'h8000_0000; ren = 1'b1;
      tick();
      checks++;
      if (rdata !== exp_st) begin errors++; $display("FAIL uart_status: got %h expected %h", rdata, exp_st); end
    end
    idle();
    uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
    tick();
  endtask

  task automatic test_counters();
    int unsigned exp_c, exp_i;
    int          n;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i < 40);
      tick();
    end
    inst_retire = 1'b0;
    addr = 32'h8000_0010; ren = 1'b1; exp_c = m_cyc;
    tick();
    checks++;
    if (rdata !== 32'(exp_c) || exp_c != 100) begin errors++; $display("FAIL cyc_ctr: got %0d expected %0d (100)", rdata, exp_c); end
    addr = 32'h8000_0014; exp_i = m_inst;
    tick();
    checks++;
    if (rdata !== 32'(exp_i) || exp_i != 40) begin errors++; $display("FAIL inst_ctr: got %0d expected %0d (40)", rdata, exp_i); end
    ren = 1'b0; addr = 32'h8000_0018; wen = 4'hF; inst_retire = 1'b1;
    tick();
    wen = '0; inst_retire = 1'b0;
    addr = 32'h8000_0010; ren = 1'b1; exp_c = m_cyc;
    tick();
    checks++;
    if (rdata !== 32'(exp_c) || exp_c != 0) begin errors++; $display("FAIL cyc_clear: got %0d expected %0d", rdata, exp_c); end
    addr = 32'h8000_0014; exp_i = m_inst;
    tick();
    checks++;
    if (rdata !== 32'(exp_i) || exp_i != 0) begin errors++; $display("FAIL inst_clear: got %0d expected %0d", rdata, exp_i); end
    idle();
    n = 0;
    while (m_cyc != MASK && n < 600) begin tick(); n++; end
    checks++;
    if (m_cyc != MASK) begin errors++; $display("FAIL wrap_wait: got %0d expected %0d", m_cyc, MASK); end
    addr = 32'h8000_0010; ren = 1'b1; exp_c = m_cyc;
    tick();
    checks++;
    if (rdata !== 32'(exp_c)) begin errors++; $display("FAIL cyc_max: got %h expected %h", rdata, exp_c); end
    exp_c = m_cyc;
    tick();
    checks++;
    if (rdata !== 32'(exp_c) || exp_c != 0) begin errors++; $display("FAIL cyc_wrap: got %h expected %h", rdata, exp_c); end
    idle();
    tick();
  endtask

  task automatic test_unmapped_and_reset();
    logic [31:0] seed_w;
    seed_w = $urandom | 32'h1;
    addr = 32'h1000_0100; wen = 4'hF; wdata = seed_w;
    ref_mem[64] = seed_w;
    tick();
    wen = '0; ren = 1'b1;
    tick();
    checks++;
    if (rdata !== ref_rd(64)) begin errors++; $display("FAIL lw_before_unmapped: got %h expected %h", rdata, ref_rd(64)); end
    addr = 32'h9000_0000;
    tick();
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL lw_unmapped: got %h expected 0", rdata); end
    addr = 32'h8000_000C;
    tick();
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL lw_io_undef: got %h expected 0", rdata); end
    addr = 32'h8000_0008;
    tick();
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL lw_io_wronly: got %h expected 0", rdata); end
    idle();
    uart_tx_ready = 1'b0;
    addr = 32'h8000_0008; wen = 4'h1; wdata = 32'h0000_00A5;
    tick();
    idle();
    checks++;
    if (uart_tx_valid !== 1'b1) begin errors++; $display("FAIL tx_pre_reset: got %b expected 1", uart_tx_valid); end
    rst_n = 1'b0;
    tick();
    checks++;
    if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00)
      begin errors++; $display("FAIL tx_abandon: got valid=%b data=%h expected 0/00", uart_tx_valid, uart_tx_data); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_after_reset: got %b expected 0", uart_tx_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0; pc_in_bios = 1'b0; inst_retire = 1'b0;
    uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = '0;
    tick();
    test_reset();
    test_dmem_basic();
    test_imem_gate();
    test_random_mem();
    test_tx();
    test_rx();
    test_counters();
    test_unmapped_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
